result_bcd_converter: RTL and testbench
=======================================

# result_bcd_converter

Downstream stage of the long-division datapath. It captures the quotient, remainder and error flag when the division control FSM raises `done`. It converts both binary values to packed BCD with a sequential shift-and-add-3 (double-dabble) engine, then presents registered digits and a one-cycle `valid` pulse to the seven-segment display driver.

## Interface
Parameters:
- `WIDTH`, 8: quotient/remainder width in bits.
- `DIGITS`, 3: BCD digits per value. Must satisfy 10^DIGITS > 2^WIDTH − 1.

Ports:
- `clk` in 1: system clock, rising edge.
- `reset` in 1: one clock; reset is asynchronous and active-high.
- `done` in 1: division-complete status from the control FSM.
- `error` in 1: divide-by-zero status from the control FSM; meaningful while `done`=1.
- `quotient` in WIDTH: binary quotient from the datapath.
- `remainder` in WIDTH: binary remainder from the datapath.
- `q_bcd` out 4·DIGITS: packed BCD quotient; digit 0 is in the LSBs. Registered.
- `r_bcd` out 4·DIGITS: packed BCD remainder. Registered.
- `err_out` out 1: high when the displayed result is an error. Registered.
- `valid` out 1: one-cycle pulse when the outputs update.
- `busy` out 1: high while a conversion is in progress.

## Operation
- Start condition: a rising edge on `done`. The block keeps a 1-bit `done_d` register and starts on `done & ~done_d`. A level held for several cycles starts exactly one conversion.
- States:
  - IDLE: on a start, capture `quotient`, `remainder` and `error`.
    - If `error`=0: load the scratch registers (binary = operand, BCD = 0), set the counter to WIDTH, and go to CONVERT.
    - If `error`=1: go to UPDATE without converting.
  - CONVERT: each cycle, for both values, add 3 to every BCD digit ≥ 5, then shift {bcd, bin} left by one bit. Decrement the counter. When the counter reaches 0 after the decrement (the WIDTH-th shift), go to UPDATE.
  - UPDATE: copy the results into `q_bcd`/`r_bcd`, write `err_out`, pulse `valid`, and return to IDLE.
- Error result: every digit of both `q_bcd` and `r_bcd` is 4'hE, and `err_out`=1.
- Normal result: `err_out`=0.
- `busy`=1 in CONVERT and UPDATE.
- Start edges seen while `busy`=1 are dropped. `done_d` still tracks `done`, so an edge during busy is not replayed later.
- `q_bcd`, `r_bcd` and `err_out` hold their value between updates.
- Arithmetic: add-3 is applied per 4-bit digit with no carry between digits. The conversion is exact for all inputs 0 … 2^WIDTH − 1.
- Reset, including mid-conversion, returns the block to:
  - state IDLE and `done_d`=0;
  - `q_bcd`=0, `r_bcd`=0, `err_out`=0, `valid`=0, `busy`=0;
  - scratch registers and counter cleared.

  The aborted conversion produces no `valid`.

## Timing
- Edge E0 samples the start edge.
- Normal path: shifts occur at edges E1…E_WIDTH. Outputs and `valid`=1 appear after edge E_WIDTH+1. The latency is WIDTH+1 cycles (9 cycles for WIDTH=8).
- Error path: outputs and `valid`=1 appear after E1 (latency 1).
- `valid` is high for exactly one cycle.
- Back-to-back operation: the earliest next start edge is sampled in the cycle after UPDATE.

## Configuration
- `BCD_LEADING_BLANK_EN` defined:
  - In normal results, every zero digit above the most significant non-zero digit is replaced by blank code 4'hF.
  - Digit 0 is never blanked.
  - Blanking is applied at UPDATE and adds no latency.
- Not defined: leading zeros are shown as 4'h0.
- Error results are unaffected in both cases.

## Test plan
- Normal conversion: WIDTH=8, `quotient`=200, `remainder`=7, 1-cycle `done` → after 9 cycles `q_bcd`=12'h200, `r_bcd`=12'h007, `err_out`=0, `valid` high 1 cycle, `busy` high cycles 1–9.
- Error path: `done`=1 with `error`=1 → after 1 cycle `q_bcd`=`r_bcd`=12'hEEE, `err_out`=1, `valid` pulse.
- Boundary values: `quotient`=255, `remainder`=0 → `q_bcd`=12'h255, `r_bcd`=12'h000.
  - Without the macro `r_bcd` is 12'h000.
  - With `BCD_LEADING_BLANK_EN`: `r_bcd`=12'hFF0, and `quotient`=5 gives `q_bcd`=12'hFF5.
- Edge/overlap: hold `done` high for 5 cycles → exactly one `valid`. A second `done` edge during cycle 4 of a conversion → ignored, and the outputs reflect only the first operands.
- Reset mid-operation: assert `reset` at cycle 4 of a conversion → all outputs 0 immediately, with no `valid`. A new `done` edge after reset (`quotient`=42, `remainder`=3) → 12'h042 / 12'h003 after 9 cycles.

Source files
------------

// File: rtl/result_bcd_converter.sv
`default_nettype none
// ============================================================================
// Module      : result_bcd_converter
// Description : Captures the quotient, remainder and error flag from the
//               long-division datapath on a rising edge of `done`. It converts
//               both values to packed BCD with a sequential shift-and-add-3
//               (double-dabble) engine. It then presents registered digits and
//               a one-cycle `valid` pulse to the seven-segment driver.
//
// Parameters  : WIDTH  - quotient/remainder width in bits
//               DIGITS - BCD digits per value (10**DIGITS > 2**WIDTH - 1)
//
// Ports       : clk        in   system clock, rising edge
//               reset      in   asynchronous, active-high reset
//               done       in   division-complete status (start on rising edge)
//               error      in   divide-by-zero status, sampled with the start
//               quotient   in   binary quotient  [WIDTH-1:0]
//               remainder  in   binary remainder [WIDTH-1:0]
//               q_bcd      out  packed BCD quotient, digit 0 in LSBs (reg)
//               r_bcd      out  packed BCD remainder (reg)
//               err_out    out  displayed result is an error (reg)
//               valid      out  one-cycle pulse when the outputs update
//               busy       out  conversion in progress (CONVERT or UPDATE)
//
// Options     : BCD_LEADING_BLANK_EN - when defined, zero digits above the most
//               significant non-zero digit of a normal result show as 4'hF.
//               Digit 0 is never blanked.
//
// Revision    : 1.0 - initial release
// ============================================================================
module result_bcd_converter #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  done,
    input  logic                  error,
    input  logic [WIDTH-1:0]      quotient,
    input  logic [WIDTH-1:0]      remainder,
    output logic [4*DIGITS-1:0]   q_bcd,
    output logic [4*DIGITS-1:0]   r_bcd,
    output logic                  err_out,
    output logic                  valid,
    output logic                  busy
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int BW = 4 * DIGITS;
    localparam logic [CW-1:0] c_CNT_ONE = CW'(1);
    localparam logic [CW-1:0] c_CNT_INIT = CW'(WIDTH);
    localparam logic [BW-1:0] c_ALL_E = {DIGITS{4'hE}};

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CONVERT = 2'd1,
        S_UPDATE  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next;

    logic                r_done_d;
    logic                w_start;

    logic [WIDTH-1:0]    r_q_bin;
    logic [WIDTH-1:0]    r_r_bin;
    logic [BW-1:0]       r_q_scr;
    logic [BW-1:0]       r_r_scr;
    logic [CW-1:0]       r_cnt;
    logic                r_err;

    logic [BW-1:0]       w_q_adj;
    logic [BW-1:0]       w_r_adj;
    logic [BW+WIDTH-1:0] w_q_shift;
    logic [BW+WIDTH-1:0] w_r_shift;
    logic [BW-1:0]       w_q_disp;
    logic [BW-1:0]       w_r_disp;

    logic [BW-1:0]       r_q_out;
    logic [BW-1:0]       r_r_out;
    logic                r_err_out;
    logic                r_valid;

    // done_d follows done in every state, so an edge that arrives while busy
    // is consumed and never replayed once the block returns to IDLE.
    assign w_start = done & ~r_done_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_done_d <= 1'b0;
        end else begin
            r_done_d <= done;
        end
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_next = error ? S_UPDATE : S_CONVERT;
                end
            end
            S_CONVERT: begin
                busy = 1'b1;
                // Counter value 1 here means this cycle performs the last shift.
                if (r_cnt == c_CNT_ONE) begin
                    w_next = S_UPDATE;
                end
            end
            S_UPDATE: begin
                busy   = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Add-3 correction, per digit, no carry between digits
    // ------------------------------------------------------------------
    generate
        for (genvar d = 0; d < DIGITS; d++) begin : g_digit
            assign w_q_adj[4*d +: 4] = (r_q_scr[4*d +: 4] >= 4'd5) ?
                                       (r_q_scr[4*d +: 4] + 4'd3) : r_q_scr[4*d +: 4];
            assign w_r_adj[4*d +: 4] = (r_r_scr[4*d +: 4] >= 4'd5) ?
                                       (r_r_scr[4*d +: 4] + 4'd3) : r_r_scr[4*d +: 4];
        end
    endgenerate

    assign w_q_shift = {w_q_adj, r_q_bin} << 1;
    assign w_r_shift = {w_r_adj, r_r_bin} << 1;

    // ------------------------------------------------------------------
    // Scratch registers and shift counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q_bin <= '0;
            r_r_bin <= '0;
            r_q_scr <= '0;
            r_r_scr <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_q_bin <= quotient;
                        r_r_bin <= remainder;
                        r_q_scr <= '0;
                        r_r_scr <= '0;
                        r_cnt   <= c_CNT_INIT;
                        r_err   <= error;
                    end
                end
                S_CONVERT: begin
                    {r_q_scr, r_q_bin} <= w_q_shift;
                    {r_r_scr, r_r_bin} <= w_r_shift;
                    r_cnt              <= r_cnt - c_CNT_ONE;
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Display formatting
    // ------------------------------------------------------------------
`ifdef BCD_LEADING_BLANK_EN
    // Walk from the top digit down; zeros stay blank until the first
    // non-zero digit. Digit 0 is always shown.
    function automatic logic [BW-1:0] blank_lead(input logic [BW-1:0] v);
        logic [BW-1:0] res;
        logic          lead;
        res  = v;
        lead = 1'b1;
        for (int d = DIGITS - 1; d >= 1; d--) begin
            if (lead && (v[4*d +: 4] == 4'h0)) begin
                res[4*d +: 4] = 4'hF;
            end else begin
                lead = 1'b0;
            end
        end
        return res;
    endfunction

    assign w_q_disp = blank_lead(r_q_scr);
    assign w_r_disp = blank_lead(r_r_scr);
`else
    assign w_q_disp = r_q_scr;
    assign w_r_disp = r_r_scr;
`endif

    // ------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q_out   <= '0;
            r_r_out   <= '0;
            r_err_out <= 1'b0;
            r_valid   <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (r_state == S_UPDATE) begin
                r_q_out   <= r_err ? c_ALL_E : w_q_disp;
                r_r_out   <= r_err ? c_ALL_E : w_r_disp;
                r_err_out <= r_err;
                r_valid   <= 1'b1;
            end
        end
    end

    assign q_bcd   = r_q_out;
    assign r_bcd   = r_r_out;
    assign err_out = r_err_out;
    assign valid   = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_result_bcd_converter.sv
`default_nettype none
// ============================================================================
// Module      : tb_result_bcd_converter
// Description : Self-checking bench for result_bcd_converter. Directed cases
//               with literal expectations, then randomized done/error/operand
//               traffic (including random resets). This traffic is compared
//               every cycle against a transaction-level model that computes the
//               BCD digits with decimal arithmetic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_result_bcd_converter;

    localparam int W  = 8;
    localparam int D  = 3;
    localparam int BW = 4 * D;

`ifdef BCD_LEADING_BLANK_EN
    localparam logic [BW-1:0] L_R7  = 12'hFF7;
    localparam logic [BW-1:0] L_R0  = 12'hFF0;
    localparam logic [BW-1:0] L_Q5  = 12'hFF5;
    localparam logic [BW-1:0] L_Q42 = 12'hF42;
    localparam logic [BW-1:0] L_R3  = 12'hFF3;
    localparam logic [BW-1:0] L_R20 = 12'hF20;
`else
    localparam logic [BW-1:0] L_R7  = 12'h007;
    localparam logic [BW-1:0] L_R0  = 12'h000;
    localparam logic [BW-1:0] L_Q5  = 12'h005;
    localparam logic [BW-1:0] L_Q42 = 12'h042;
    localparam logic [BW-1:0] L_R3  = 12'h003;
    localparam logic [BW-1:0] L_R20 = 12'h020;
`endif

    logic          clk;
    logic          reset;
    logic          done;
    logic          error;
    logic [W-1:0]  quotient;
    logic [W-1:0]  remainder;
    logic [BW-1:0] q_bcd;
    logic [BW-1:0] r_bcd;
    logic          err_out;
    logic          valid;
    logic          busy;

    int n_checks = 0;
    int n_pass   = 0;

    result_bcd_converter #(.WIDTH(W), .DIGITS(D)) dut (
        .clk       (clk),
        .reset     (reset),
        .done      (done),
        .error     (error),
        .quotient  (quotient),
        .remainder (remainder),
        .q_bcd     (q_bcd),
        .r_bcd     (r_bcd),
        .err_out   (err_out),
        .valid     (valid),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Decimal digits by repeated division; optional leading-zero blanking.
    function automatic logic [BW-1:0] exp_bcd(input int v);
        logic [BW-1:0] res;
        int            x;
        logic          lead;
        x    = v;
        res  = '0;
        for (int d = 0; d < D; d++) begin
            res[4*d +: 4] = 4'(x % 10);
            x = x / 10;
        end
        lead = 1'b1;
`ifdef BCD_LEADING_BLANK_EN
        for (int d = D - 1; d >= 1; d--) begin
            if (lead && res[4*d +: 4] == 4'h0) res[4*d +: 4] = 4'hF;
            else lead = 1'b0;
        end
`endif
        return res;
    endfunction

    // ------------------------------------------------------------------
    // Transaction-level model: a start that is not dropped produces a
    // result exactly `lat` edges later (1 for error, W+1 otherwise).
    // ------------------------------------------------------------------
    logic [BW-1:0] m_q = '0, m_r = '0, p_q = '0, p_r = '0;
    logic          m_err = 1'b0, p_err = 1'b0, m_valid = 1'b0, m_done_prev = 1'b0;
    int            m_left = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_q <= '0; m_r <= '0; m_err <= 1'b0; m_valid <= 1'b0;
            m_left <= 0; m_done_prev <= 1'b0;
        end else begin
            m_done_prev <= done;
            m_valid     <= 1'b0;
            if (m_left != 0) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_q <= p_q; m_r <= p_r; m_err <= p_err; m_valid <= 1'b1;
                end
            end else if (done && !m_done_prev) begin
                p_err  <= error;
                p_q    <= error ? {D{4'hE}} : exp_bcd(int'(quotient));
                p_r    <= error ? {D{4'hE}} : exp_bcd(int'(remainder));
                m_left <= error ? 1 : W + 1;
            end
        end
    end

    always @(negedge clk) begin
        chk("q_bcd",   32'(q_bcd),   32'(m_q));
        chk("r_bcd",   32'(r_bcd),   32'(m_r));
        chk("err_out", 32'(err_out), 32'(m_err));
        chk("valid",   32'(valid),   32'(m_valid));
        chk("busy",    32'(busy),    32'(m_left != 0));
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (inputs change on the falling edge)
    // ------------------------------------------------------------------
    task automatic start(input int q, input int r, input logic e);
        @(negedge clk);
        quotient  = 8'(q);
        remainder = 8'(r);
        error     = e;
        done      = 1'b1;
        @(negedge clk);
        done      = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = -1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (valid === 1'b1) begin
                lat = k;
                break;
            end
        end
        if (lat < 0) begin
            n_checks++;
            $display("FAIL valid_timeout: got no valid expected pulse within 30 cycles at %0t", $time);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1, "timeout");
    end

    int lat;
    int vcount;

    initial begin
        reset = 1'b1; done = 1'b0; error = 1'b0; quotient = '0; remainder = '0;
        repeat (3) @(negedge clk);
        chk("rst_q",     32'(q_bcd),   32'h0);
        chk("rst_r",     32'(r_bcd),   32'h0);
        chk("rst_err",   32'(err_out), 32'h0);
        chk("rst_valid", 32'(valid),   32'h0);
        chk("rst_busy",  32'(busy),    32'h0);
        reset = 1'b0;

        // Normal conversion, latency W+1
        start(200, 7, 1'b0);
        chk("busy_after_start", 32'(busy), 32'h1);
        wait_valid(lat);
        chk("lat_normal", 32'(lat),     32'd9);
        chk("q_200",      32'(q_bcd),   32'h200);
        chk("r_7",        32'(r_bcd),   32'(L_R7));
        chk("err_normal", 32'(err_out), 32'h0);
        @(negedge clk);
        chk("valid_one_cycle", 32'(valid), 32'h0);

        // Error path, latency 1
        start(13, 9, 1'b1);
        wait_valid(lat);
        chk("lat_error", 32'(lat),     32'd1);
        chk("q_err",     32'(q_bcd),   32'hEEE);
        chk("r_err",     32'(r_bcd),   32'hEEE);
        chk("err_set",   32'(err_out), 32'h1);

        // Boundary values
        start(255, 0, 1'b0);
        wait_valid(lat);
        chk("q_255", 32'(q_bcd), 32'h255);
        chk("r_0",   32'(r_bcd), 32'(L_R0));
        chk("err_clear", 32'(err_out), 32'h0);
        start(5, 0, 1'b0);
        wait_valid(lat);
        chk("q_5", 32'(q_bcd), 32'(L_Q5));

        // Level held for 5 cycles starts exactly one conversion
        @(negedge clk);
        quotient = 8'd77; remainder = 8'd1; error = 1'b0; done = 1'b1;
        vcount = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (k == 4) done = 1'b0;
            if (valid === 1'b1) vcount++;
        end
        chk("held_done_valids", 32'(vcount), 32'd1);

        // Second edge during a conversion is dropped
        start(100, 20, 1'b0);
        @(negedge clk);
        @(negedge clk);
        quotient = 8'd33; remainder = 8'd44; done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        wait_valid(lat);
        chk("overlap_q", 32'(q_bcd), 32'h100);
        chk("overlap_r", 32'(r_bcd), 32'(L_R20));
        vcount = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (valid === 1'b1) vcount++;
        end
        chk("overlap_no_replay", 32'(vcount), 32'd0);

        // Reset in the middle of a conversion
        start(123, 45, 1'b0);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("midrst_q",     32'(q_bcd),   32'h0);
        chk("midrst_r",     32'(r_bcd),   32'h0);
        chk("midrst_err",   32'(err_out), 32'h0);
        chk("midrst_valid", 32'(valid),   32'h0);
        chk("midrst_busy",  32'(busy),    32'h0);
        @(negedge clk);
        reset = 1'b0;
        vcount = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (valid === 1'b1) vcount++;
        end
        chk("midrst_no_valid", 32'(vcount), 32'd0);
        start(42, 3, 1'b0);
        wait_valid(lat);
        chk("lat_after_rst", 32'(lat),   32'd9);
        chk("q_42",          32'(q_bcd), 32'(L_Q42));
        chk("r_3",           32'(r_bcd), 32'(L_R3));

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            reset = ($urandom_range(0, 399) == 0);
            done  = ($urandom_range(0, 3) == 0);
            error = ($urandom_range(0, 5) == 0);
            case ($urandom_range(0, 7))
                0:       quotient = 8'd0;
                1:       quotient = 8'd255;
                default: quotient = 8'($urandom);
            endcase
            case ($urandom_range(0, 7))
                0:       remainder = 8'd0;
                1:       remainder = 8'd255;
                default: remainder = 8'($urandom);
            endcase
        end
        @(negedge clk);
        reset = 1'b0; done = 1'b0;
        repeat (15) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
